pam_pulse_gen: RTL
==================

Name: pam_pulse_gen

Overview:
PAM transmitter. It generates a periodic train of triangular pulses whose peak amplitude is taken, one value per pulse, from a valid/ready sample stream. It is the source-side counterpart of the pulse-period/phase measurement chain. It emits per-frame start and peak markers so downstream timing logic and benches can correlate the generated pulses with measured period and phase.

Parameters:
DW, 16, amplitude sample width (unsigned)
PW, 21, period counter width (cycles per frame)
HW, 10, half-width width (cycles from pulse start to peak)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; sampled only in IDLE and at frame boundaries
period  in  PW  frame length P in cycles; latched at frame start
half_width  in  HW  pulse half-width H in cycles; latched at frame start
amp_valid  in  1  amplitude sample available
amp  in  DW  unsigned pulse amplitude a
amp_ready  out  1  block consumes amp this cycle (frame-start cycle only)
sample_out  out  DW+HW  registered pulse sample
frame_start  out  1  one-cycle pulse coincident with the first sample of a frame
peak_mark  out  1  one-cycle pulse coincident with the peak sample
busy  out  1  frame in progress
underrun  out  1  sticky: a frame started with amp_valid low
cfg_err  out  1  one-cycle pulse: illegal P/H latched

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counters=0. All outputs are 0: sample_out, frame_start, peak_mark, busy, underrun, cfg_err, amp_ready. Reset mid-frame aborts immediately. After release, operation restarts from IDLE.
- States: IDLE, RUN. Internal frame index t runs 0..P-1 in RUN.
- Frame-start cycle F:
  - F is the cycle in IDLE with enable=1, or the cycle after t=P-1 when enable=1 at t=P-1.
  - If enable=0 at t=P-1, the state goes to IDLE after the frame completes. Dropping enable mid-frame never truncates a frame.
- At F:
  - amp_ready=1. amp_ready depends only on state/counter, never on amp_valid.
  - If amp_valid=1, latch a=amp. Otherwise latch a=0 and set underrun (sticky until reset).
  - Latch P=period and H=half_width. Input changes outside F have no effect on the current frame.
- Output latency: sample_out at cycle F+1+t equals s(t).
  - s(t) = a*t for 0<=t<=H.
  - s(t) = a*(2H-t) for H<t<=2H.
  - s(t) = 0 for 2H<t<P.
  - Generate s(t) by accumulate/decrement of a (no multiplier required). Peak a*H fits DW+HW bits, so no overflow or saturation is possible.
- frame_start=1 at cycle F+1 (s(0)). peak_mark=1 at cycle F+1+H.
- busy=1 from F+1 through the last sample of the last frame. busy=0 and sample_out=0 in IDLE.
- Back-to-back frames: with enable held high, frame_start recurs every exactly P cycles with no gap cycle. The last sample of frame k is followed directly by s(0) of frame k+1.
- Config error: H==0 or P<2H+1.
  - The frame still runs for max(P,1) cycles, with all samples 0 and no peak_mark.
  - cfg_err=1 at F+1. The amplitude is still consumed.
  - P==0 is treated as P=1.
- Simultaneous events: a new frame start and the end of the previous frame coincide by construction. No other event ordering exists.
- Widths: t counter is PW bits. Comparisons use zero-extended H (2H+1 computed in HW+2 bits).

Test Plan:
- Basic: P=20, H=4, amp=100 valid, enable=1 → sample_out = 0,100,200,300,400,300,200,100,0 then eleven 0s. frame_start at s(0), peak_mark at s=400, amp_ready high for exactly one cycle per frame, underrun=0.
- Back-to-back with amp stream 10,20,30 → frame_start every 20 cycles. Peaks are 40, 80, 120. Each amp is consumed exactly at its frame's amp_ready cycle. Changing period to 12 mid-frame 2 takes effect only at frame 3.
- Underrun: amp_valid=0 at frame 2's F → frame 2 is all zeros, underrun=1 and stays 1 in later valid frames until rst_n pulse.
- Config error: P=8, H=4 → cfg_err one-cycle pulse at F+1, 8 zero samples, no peak_mark. The next frame with P=9, H=4 gives peak 4a.
- Enable drop mid-frame (t=6 of P=20) → the frame completes all 20 samples, then IDLE. busy falls after the last sample and no further amp_ready occurs.
- Extremes and reset: amp=0xFFFF, H=1023, P=2047 → peak 0xFFFF*1023=0x3FEFC01 exact, symmetric decay. Asserting rst_n=0 at t=500 clears all outputs immediately. Re-enabling starts a fresh frame from s(0).

Source files
------------

// File: rtl/pam_pulse_gen.sv
// -----------------------------------------------------------------------------
// pam_pulse_gen
//
// PAM transmitter. Emits a periodic train of triangular pulses. Each pulse
// takes its peak amplitude from one sample of a valid/ready stream. Per-frame
// start and peak markers let downstream timing logic line the generated pulses
// up with measured period and phase.
//
// Frame of P cycles, half-width H, amplitude a. Sample t of the frame is:
//   s(t) = a*t        for 0 <= t <= H
//   s(t) = a*(2H-t)   for H < t <= 2H
//   s(t) = 0          for 2H < t < P
// s(t) appears on sample_out at cycle F+1+t, where F is the frame-start cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      run request; sampled in IDLE and on the last cycle of a frame
//   period      frame length P in cycles, latched at frame start
//   half_width  pulse half-width H in cycles, latched at frame start
//   amp_valid   amplitude sample available
//   amp         unsigned pulse amplitude
//   amp_ready   amp is consumed this cycle (frame-start cycle only)
//   sample_out  registered pulse sample
//   frame_start one-cycle marker on s(0)
//   peak_mark   one-cycle marker on the peak sample s(H)
//   busy        a frame is in progress
//   underrun    sticky: a frame started without a valid amplitude
//   cfg_err     one-cycle marker on s(0) of a frame with illegal P/H
// -----------------------------------------------------------------------------
module pam_pulse_gen #(
  parameter int DW = 16,
  parameter int PW = 21,
  parameter int HW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PW-1:0]    period,
  input  logic [HW-1:0]    half_width,
  input  logic             amp_valid,
  input  logic [DW-1:0]    amp,
  output logic             amp_ready,
  output logic [DW+HW-1:0] sample_out,
  output logic             frame_start,
  output logic             peak_mark,
  output logic             busy,
  output logic             underrun,
  output logic             cfg_err
);

  localparam int SW = DW + HW;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] t_cnt;     // index of the sample currently on sample_out
  logic [PW-1:0] p_last;    // latched max(P,1) - 1
  logic [HW-1:0] h_lat;
  logic [DW-1:0] a_lat;
  logic          cfg_bad;   // latched illegal-config flag for the current frame
  logic [SW-1:0] sample_q;
  logic          frame_start_q;
  logic          peak_mark_q;
  logic          underrun_q;
  logic          cfg_err_q;

  // Frame start happens either from IDLE or on the last sample of a running
  // frame, so consecutive frames leave no gap cycle.
  logic frame_go;
  assign frame_go = enable & ((state == ST_IDLE) | (t_cnt == p_last));

  // Without the rst_n term, amp_ready would be high during reset whenever
  // enable is high, because reset forces the state to IDLE.
  assign amp_ready = rst_n & frame_go;

  // Configuration check on the values about to be latched. 2H+1 is formed by
  // appending a 1 below H, then zero-extended to the counter width.
  logic [PW-1:0] min_period;
  logic          cfg_bad_in;
  logic [PW-1:0] p_last_in;

  assign min_period = PW'({half_width, 1'b1});
  assign cfg_bad_in = (half_width == '0) || (period < min_period);
  // P == 0 runs as a one-cycle frame.
  assign p_last_in  = (period == '0) ? '0 : period - PW'(1);

  // Next-sample generation by accumulate/decrement. No multiplier is needed.
  // The peak a*H fits in SW bits, so the accumulator never wraps.
  logic [PW-1:0] t_next;
  logic [PW-1:0] h_ext;
  logic [PW-1:0] two_h;
  logic [SW-1:0] sample_next;
  logic          peak_next;

  assign t_next = t_cnt + PW'(1);
  assign h_ext  = PW'(h_lat);
  assign two_h  = PW'({h_lat, 1'b0});

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    sample_next = '0;
    if (!cfg_bad) begin
      if (t_cnt < h_ext)      sample_next = sample_q + SW'(a_lat);
      else if (t_cnt < two_h) sample_next = sample_q - SW'(a_lat);
    end
  end

  assign peak_next = !cfg_bad && (t_next == h_ext);

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // in a block then update together at the edge, independent of the order of
  // the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      t_cnt         <= '0;
      p_last        <= '0;
      h_lat         <= '0;
      a_lat         <= '0;
      cfg_bad       <= 1'b0;
      sample_q      <= '0;
      frame_start_q <= 1'b0;
      peak_mark_q   <= 1'b0;
      underrun_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      peak_mark_q   <= 1'b0;
      cfg_err_q     <= 1'b0;

      if (frame_go) begin
        // Frame-start cycle F: consume amp and latch the whole frame config.
        state         <= ST_RUN;
        t_cnt         <= '0;
        p_last        <= p_last_in;
        h_lat         <= half_width;
        a_lat         <= amp_valid ? amp : '0;
        cfg_bad       <= cfg_bad_in;
        sample_q      <= '0;
        frame_start_q <= 1'b1;
        cfg_err_q     <= cfg_bad_in;
        if (!amp_valid) underrun_q <= 1'b1;
      end else if (state == ST_RUN) begin
        if (t_cnt == p_last) begin
          // Last sample shown and enable is low: return to IDLE.
          state    <= ST_IDLE;
          t_cnt    <= '0;
          sample_q <= '0;
        end else begin
          t_cnt       <= t_next;
          sample_q    <= sample_next;
          peak_mark_q <= peak_next;
        end
      end
    end
  end

  assign sample_out  = sample_q;
  assign frame_start = frame_start_q;
  assign peak_mark   = peak_mark_q;
  assign busy        = (state == ST_RUN);
  assign underrun    = underrun_q;
  assign cfg_err     = cfg_err_q;

endmodule
